// File: rtl/bcd_stopwatch_counter_pkg.sv
// Shared types and helpers for the two-digit BCD stopwatch.
// Holds the control-state encoding and BCD nibble constants.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    PAUSED = 2'd2
  } state_e;

  localparam logic [3:0] BCD_MAX  = 4'd9;
  localparam logic [3:0] BCD_ZERO = 4'd0;

  function automatic logic [3:0] bcd_clamp(input logic [3:0] nib);
    if (nib > BCD_MAX) begin
      return BCD_MAX;
    end else begin
      return nib;
    end
  endfunction

endpackage

// File: rtl/bcd_stopwatch_counter_tick_prescaler.sv
// Divides CLOCK_50 down to a one-cycle count tick every TICK_DIV cycles.
// en means "running during the next cycle"; the count itself advances while running.
module tick_prescaler #(
  parameter int TICK_DIV = 50000000
) (
  input  logic CLOCK_50,
  input  logic Resetn,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int CNT_W = $clog2(TICK_DIV);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             run_q;
  logic             tick_q, tick_d;

  // Next prescaler value; a partial period is kept while not running.
  always_comb begin
    cnt_d  = cnt_q;
    tick_d = 1'b0;
    if (clr) begin
      cnt_d = {CNT_W{1'b0}};
    end else if (run_q) begin
      cnt_d = (cnt_q == LAST) ? {CNT_W{1'b0}} : cnt_q + CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
    tick_d = en & ~clr & (cnt_d == LAST);
  end

  // Prescaler state registers.
  always_ff @(posedge CLOCK_50) begin
    if (!Resetn) begin
      cnt_q  <= {CNT_W{1'b0}};
      run_q  <= 1'b0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      run_q  <= en;
      tick_q <= tick_d;
    end
  end

  assign tick = tick_q;

endmodule

// File: rtl/bcd_stopwatch_counter.sv
// Two-digit BCD up/down stopwatch with run/pause control, clear and clamped load.
// Digits, wrap and running are registered; tick comes from the prescaler.
module bcd_stopwatch_counter
  import stopwatch_pkg::*;
#(
  parameter int TICK_DIV = 50000000
) (
  input  logic       CLOCK_50,
  input  logic       Resetn,
  input  logic       start_stop,
  input  logic       clear,
  input  logic       up,
  input  logic       load,
  input  logic [7:0] load_val,
  output logic [3:0] digit0,
  output logic [3:0] digit1,
  output logic       running,
  output logic       tick,
  output logic       wrap
);

  state_e     state_q, state_d;
  logic       ss_q;
  logic [3:0] d0_q, d0_d;
  logic [3:0] d1_q, d1_d;
  logic       wrap_q, wrap_d;
  logic       running_q;
  logic       ss_edge;
  logic       step;
  logic       tick_s;

  tick_prescaler #(.TICK_DIV(TICK_DIV)) u_prescaler (
    .CLOCK_50 (CLOCK_50),
    .Resetn   (Resetn),
    .en       (state_d == RUN),
    .clr      (clear | load),
    .tick     (tick_s)
  );

  // Next state and next digit values, in priority order clear > load > edge > tick.
  always_comb begin
    ss_edge = start_stop & ~ss_q;
    step    = tick_s & ~clear & ~load;
    state_d = state_q;
    d0_d    = d0_q;
    d1_d    = d1_q;
    wrap_d  = 1'b0;

    if (clear) begin
      state_d = IDLE;
    end else if (load) begin
      state_d = PAUSED;
    end else if (ss_edge) begin
      state_d = (state_q == RUN) ? PAUSED : RUN;
    end else begin
      state_d = state_q;
    end

    if (clear) begin
      d0_d = BCD_ZERO;
      d1_d = BCD_ZERO;
    end else if (load) begin
      d0_d = bcd_clamp(load_val[3:0]);
      d1_d = bcd_clamp(load_val[7:4]);
    end else if (step && up) begin
      if (d0_q >= BCD_MAX) begin
        d0_d = BCD_ZERO;
        if (d1_q >= BCD_MAX) begin
          d1_d   = BCD_ZERO;
          wrap_d = 1'b1;
        end else begin
          d1_d = d1_q + 4'd1;
        end
      end else begin
        d0_d = d0_q + 4'd1;
      end
    end else if (step) begin
      // Down count; out-of-range values cannot occur but still land on a legal digit.
      if (d0_q == BCD_ZERO || d0_q > BCD_MAX) begin
        d0_d = BCD_MAX;
        if (d1_q == BCD_ZERO || d1_q > BCD_MAX) begin
          d1_d   = BCD_MAX;
          wrap_d = 1'b1;
        end else begin
          d1_d = d1_q - 4'd1;
        end
      end else begin
        d0_d = d0_q - 4'd1;
      end
    end else begin
      d0_d = d0_q;
      d1_d = d1_q;
    end
  end

  // Control FSM and registered outputs.
  always_ff @(posedge CLOCK_50) begin
    if (!Resetn) begin
      state_q   <= IDLE;
      ss_q      <= 1'b0;
      d0_q      <= BCD_ZERO;
      d1_q      <= BCD_ZERO;
      wrap_q    <= 1'b0;
      running_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ss_q      <= start_stop;
      d0_q      <= d0_d;
      d1_q      <= d1_d;
      wrap_q    <= wrap_d;
      running_q <= (state_d == RUN);
    end
  end

  assign digit0  = d0_q;
  assign digit1  = d1_q;
  assign running = running_q;
  assign tick    = tick_s;
  assign wrap    = wrap_q;

endmodule

// File: tb/tb_bcd_stopwatch_counter.sv
// Directed self-checking bench for bcd_stopwatch_counter with TICK_DIV=4.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_bcd_stopwatch_counter;

  logic       CLOCK_50 = 1'b0;
  logic       Resetn;
  logic       start_stop;
  logic       clear;
  logic       up;
  logic       load;
  logic [7:0] load_val;
  logic [3:0] digit0;
  logic [3:0] digit1;
  logic       running;
  logic       tick;
  logic       wrap;

  int checks = 0;
  int failures = 0;

  bcd_stopwatch_counter #(.TICK_DIV(4)) dut (
    .CLOCK_50   (CLOCK_50),
    .Resetn     (Resetn),
    .start_stop (start_stop),
    .clear      (clear),
    .up         (up),
    .load       (load),
    .load_val   (load_val),
    .digit0     (digit0),
    .digit1     (digit1),
    .running    (running),
    .tick       (tick),
    .wrap       (wrap)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic press();
    start_stop = 1'b1;
    step();
    start_stop = 1'b0;
  endtask

  function automatic logic [7:0] bcd(input int n);
    return {4'(n / 10), 4'(n % 10)};
  endfunction

  // Called from the first cycle of a period; ends on the cycle showing the new count.
  task automatic next_tick(input logic [7:0] exp, input logic [7:0] prev, input logic exp_wrap);
    repeat (2) begin
      step();
      chk("tick_low", {7'd0, tick}, 8'd0);
      chk("wrap_low", {7'd0, wrap}, 8'd0);
    end
    step();
    chk("tick_high", {7'd0, tick}, 8'd1);
    chk("digits_at_tick", {digit1, digit0}, prev);
    step();
    chk("digits_after_tick", {digit1, digit0}, exp);
    chk("wrap_after_tick", {7'd0, wrap}, {7'd0, exp_wrap});
    chk("tick_cleared", {7'd0, tick}, 8'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog time limit expired");
    $fatal(1, "watchdog");
  end

  initial begin
    Resetn = 1'b0; start_stop = 1'b0; clear = 1'b0; up = 1'b1; load = 1'b0; load_val = 8'h00;
    step();
    step();
    chk("rst_digits", {digit1, digit0}, 8'h00);
    chk("rst_running", {7'd0, running}, 8'd0);
    chk("rst_tick", {7'd0, tick}, 8'd0);
    chk("rst_wrap", {7'd0, wrap}, 8'd0);
    Resetn = 1'b1;

    // Count up 12 ticks from 00, checking the 4-cycle period.
    press();
    chk("start_running", {7'd0, running}, 8'd1);
    chk("start_tick", {7'd0, tick}, 8'd0);
    for (int i = 1; i <= 12; i++) begin
      next_tick(bcd(i), bcd(i - 1), 1'b0);
    end
    chk("count_12", {digit1, digit0}, 8'h12);

    // Up wrap 99 -> 00 and clamped loads.
    load_val = 8'h98; load = 1'b1;
    step();
    load = 1'b0;
    chk("load_98", {digit1, digit0}, 8'h98);
    chk("load_pauses", {7'd0, running}, 8'd0);
    press();
    next_tick(8'h99, 8'h98, 1'b0);
    next_tick(8'h00, 8'h99, 1'b1);
    step();
    chk("wrap_one_cycle", {7'd0, wrap}, 8'd0);
    chk("after_wrap_00", {digit1, digit0}, 8'h00);
    load_val = 8'hFA; load = 1'b1;
    step();
    chk("load_FA_clamp", {digit1, digit0}, 8'h99);
    chk("load_running", {7'd0, running}, 8'd0);
    load_val = 8'hA3;
    step();
    load = 1'b0;
    chk("load_A3_clamp", {digit1, digit0}, 8'h93);

    // Down wrap 00 -> 99, then borrow 40 -> 39.
    clear = 1'b1;
    step();
    clear = 1'b0;
    chk("clear_00", {digit1, digit0}, 8'h00);
    chk("clear_no_wrap", {7'd0, wrap}, 8'd0);
    up = 1'b0;
    press();
    next_tick(8'h99, 8'h00, 1'b1);
    next_tick(8'h98, 8'h99, 1'b0);
    load_val = 8'h40; load = 1'b1;
    step();
    load = 1'b0;
    press();
    next_tick(8'h39, 8'h40, 1'b0);

    // Pause two cycles into a period, hold, resume.
    up = 1'b1;
    step();
    press();
    chk("pause_running", {7'd0, running}, 8'd0);
    repeat (10) begin
      step();
      chk("pause_hold_digits", {digit1, digit0}, 8'h39);
      chk("pause_no_tick", {7'd0, tick}, 8'd0);
    end
    press();
    chk("resume_running", {7'd0, running}, 8'd1);
    chk("resume_tick_low", {7'd0, tick}, 8'd0);
    step();
    chk("resume_tick_high", {7'd0, tick}, 8'd1);
    step();
    chk("resume_count", {digit1, digit0}, 8'h40);

    // Held-high start_stop toggles only once.
    start_stop = 1'b1;
    step();
    chk("held_first_toggle", {7'd0, running}, 8'd0);
    repeat (19) begin
      step();
      chk("held_no_retrigger", {7'd0, running}, 8'd0);
      chk("held_digits", {digit1, digit0}, 8'h40);
    end
    start_stop = 1'b0;
    step();
    chk("held_release", {7'd0, running}, 8'd0);

    // clear beats load beats start_stop edge.
    clear = 1'b1; load = 1'b1; load_val = 8'h55; start_stop = 1'b1;
    step();
    clear = 1'b0; load = 1'b0; start_stop = 1'b0;
    chk("prio_digits", {digit1, digit0}, 8'h00);
    chk("prio_running", {7'd0, running}, 8'd0);
    repeat (6) begin
      step();
      chk("idle_hold", {digit1, digit0}, 8'h00);
      chk("idle_running", {7'd0, running}, 8'd0);
    end

    // Tick coincident with a pause edge still counts.
    press();
    step();
    step();
    step();
    chk("pause_tick_high", {7'd0, tick}, 8'd1);
    start_stop = 1'b1;
    step();
    start_stop = 1'b0;
    chk("pause_tick_count", {digit1, digit0}, 8'h01);
    chk("pause_tick_running", {7'd0, running}, 8'd0);
    chk("pause_tick_low", {7'd0, tick}, 8'd0);
    repeat (4) begin
      step();
      chk("pause_tick_hold", {digit1, digit0}, 8'h01);
    end

    // Reset in RUN at 37 clears everything.
    load_val = 8'h37; load = 1'b1;
    step();
    load = 1'b0;
    chk("load_37", {digit1, digit0}, 8'h37);
    press();
    step();
    step();
    Resetn = 1'b0;
    step();
    Resetn = 1'b1;
    chk("midrun_rst_digits", {digit1, digit0}, 8'h00);
    chk("midrun_rst_running", {7'd0, running}, 8'd0);
    chk("midrun_rst_tick", {7'd0, tick}, 8'd0);
    chk("midrun_rst_wrap", {7'd0, wrap}, 8'd0);
    repeat (8) begin
      step();
      chk("post_rst_digits", {digit1, digit0}, 8'h00);
      chk("post_rst_tick", {7'd0, tick}, 8'd0);
      chk("post_rst_running", {7'd0, running}, 8'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
